// File: rtl/display_column_scheduler.sv
// Column scheduler: snapshots channel values per frame and streams thermometer bars.
// Optional peak-hold indicator is built when PEAK_HOLD_EN is defined.
module display_column_scheduler #(
  parameter int NUM_COLS = 16,
  parameter int VAL_W    = 16,
  parameter int ROWS     = 8,
  parameter int SHIFT    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_req,
  input  logic [NUM_COLS*VAL_W-1:0] values_in,
  output logic                      col_valid,
  input  logic                      col_ready,
  output logic [$clog2(NUM_COLS)-1:0] col_index,
  output logic [ROWS-1:0]           col_bar,
`ifdef PEAK_HOLD_EN
  output logic [ROWS-1:0]           col_peak,
`endif
  output logic                      frame_busy,
  output logic                      frame_done,
  output logic [7:0]                overrun_cnt
);

  localparam int IW = $clog2(NUM_COLS);
  localparam int LW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  function automatic logic [LW-1:0] f_lvl(
    input logic [VAL_W-1:0] v
  );
    logic [VAL_W-1:0] s;
    s = v >> SHIFT;
    if (s > VAL_W'(ROWS)) return LW'(ROWS);
    return s[LW-1:0];
  endfunction

  function automatic logic [ROWS-1:0] f_bar(
    input logic [LW-1:0] l
  );
    logic [ROWS-1:0] b;
    for (int i = 0; i < ROWS; i++)
      b[i] = (i < int'(l));
    return b;
  endfunction

  state_t          r_state;
  logic [LW-1:0]   r_lvl [NUM_COLS];
  logic [LW-1:0]   w_lvl0;
  logic [IW-1:0]   w_nidx;
  logic            w_hs;
  logic            w_last;

  assign w_lvl0 = f_lvl(values_in[VAL_W-1:0]);
  assign w_nidx = col_index + IW'(1);
  assign w_hs   = col_valid & col_ready;
  assign w_last = (col_index == IW'(NUM_COLS - 1));

  // Levels are captured once in LOAD so late input changes cannot tear a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      col_valid   <= 1'b0;
      col_index   <= '0;
      col_bar     <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= '0;
      for (int i = 0; i < NUM_COLS; i++)
        r_lvl[i] <= '0;
    end else begin
      if (frame_req && r_state != S_IDLE &&
          overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
      unique case (r_state)
        S_IDLE: begin
          if (frame_req) begin
            r_state    <= S_LOAD;
            frame_busy <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_COLS; i++)
            r_lvl[i] <= f_lvl(values_in[i*VAL_W +: VAL_W]);
          col_index <= '0;
          col_bar   <= f_bar(w_lvl0);
          col_valid <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            if (w_last) begin
              col_valid  <= 1'b0;
              frame_done <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              col_index <= w_nidx;
              col_bar   <= f_bar(r_lvl[w_nidx]);
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          frame_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PEAK_HOLD_EN
  function automatic logic [LW-1:0] f_max(
    input logic [LW-1:0] a,
    input logic [LW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic [ROWS-1:0] f_hot(
    input logic [LW-1:0] l
  );
    logic [ROWS-1:0] b;
    for (int i = 0; i < ROWS; i++)
      b[i] = ((i + 1) == int'(l));
    return b;
  endfunction

  logic [LW-1:0] r_peak [NUM_COLS];
  logic [LW-1:0] w_show0;
  logic [LW-1:0] w_shown;
  logic [LW-1:0] w_cur;

  assign w_show0 = f_max(r_peak[0], w_lvl0);
  assign w_shown = f_max(r_peak[w_nidx], r_lvl[w_nidx]);
  assign w_cur   = f_max(r_peak[col_index], r_lvl[col_index]);

  // Peak shown with a column already includes that column's own level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_peak <= '0;
      for (int i = 0; i < NUM_COLS; i++)
        r_peak[i] <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        col_peak <= f_hot(w_show0);
      end else if (r_state == S_SEND && w_hs) begin
        r_peak[col_index] <= w_cur;
        if (!w_last)
          col_peak <= f_hot(w_shown);
      end else if (r_state == S_DONE) begin
        for (int i = 0; i < NUM_COLS; i++)
          if (r_peak[i] != '0)
            r_peak[i] <= r_peak[i] - LW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_display_column_scheduler.sv
// Randomized bench for display_column_scheduler against a level/bar queue model.
// Builds with or without PEAK_HOLD_EN.
module tb_display_column_scheduler;

  localparam int N  = 16;
  localparam int VW = 16;
  localparam int R  = 8;
  localparam int SH = 0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_req;
  logic [N*VW-1:0] values_in;
  logic          col_valid;
  logic          col_ready;
  logic [3:0]    col_index;
  logic [R-1:0]  col_bar;
`ifdef PEAK_HOLD_EN
  logic [R-1:0]  col_peak;
`endif
  logic          frame_busy;
  logic          frame_done;
  logic [7:0]    overrun_cnt;

  int checks  = 0;
  int errors  = 0;
  int exp_ovr = 0;
  int pk [N];

  always #5 clk = ~clk;

  display_column_scheduler #(
    .NUM_COLS(N), .VAL_W(VW), .ROWS(R), .SHIFT(SH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_req(frame_req),
    .values_in(values_in),
    .col_valid(col_valid),
    .col_ready(col_ready),
    .col_index(col_index),
    .col_bar(col_bar),
`ifdef PEAK_HOLD_EN
    .col_peak(col_peak),
`endif
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_lvl(input int v);
    int l;
    l = v >> SH;
    return (l > R) ? R : l;
  endfunction

  function automatic int ref_bar(input int l);
    return (1 << l) - 1;
  endfunction

  function automatic int ref_hot(input int l);
    return (l == 0) ? 0 : (1 << (l - 1));
  endfunction

  function automatic int val_of(input int i);
    return int'(values_in[i*VW +: VW]);
  endfunction

  task automatic bump_ovr();
    if (exp_ovr < 255) exp_ovr++;
  endtask

  task automatic rand_values(input int maxv);
    for (int i = 0; i < N; i++)
      values_in[i*VW +: VW] = VW'($urandom_range(0, maxv));
  endtask

  task automatic run_frame(input bit rnd_ready,
                           input int n_extra,
                           input bit req_at_done,
                           input bit full_speed);
    int lv [N];
    int k = 0;
    int c = 0;
    int extra = 0;
    int done_at = -1;
    bit hs;
    for (int i = 0; i < N; i++)
      lv[i] = ref_lvl(val_of(i));
    frame_req = 1'b1;
    step();
    c = 1;
    frame_req = 1'b0;
    chk("busy_after_req", 32'(frame_busy), 1);
    chk("valid_in_load", 32'(col_valid), 0);
    while (done_at < 0 && c < 2000) begin
      if (frame_done) begin
        done_at = c;
      end else begin
        if (c >= 2 && k < N) begin
          chk("valid_in_send", 32'(col_valid), 1);
          chk("col_index", 32'(col_index), k);
          chk("col_bar", 32'(col_bar), ref_bar(lv[k]));
`ifdef PEAK_HOLD_EN
          chk("col_peak", 32'(col_peak),
              ref_hot(pk[k] > lv[k] ? pk[k] : lv[k]));
`endif
        end else if (k >= N) begin
          chk("valid_after_last", 32'(col_valid), 0);
        end
        col_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (extra < n_extra && c >= 3 && (c % 2) == 1) begin
          frame_req = 1'b1;
          rand_values(20);
          extra++;
          bump_ovr();
        end else begin
          frame_req = 1'b0;
        end
        hs = col_valid && col_ready;
        step();
        c++;
        if (hs) begin
          if (k < N && lv[k] > pk[k]) pk[k] = lv[k];
          k++;
        end
      end
    end
    frame_req = 1'b0;
    chk("frame_done_seen", 32'(done_at >= 0), 1);
    chk("cols_sent", k, N);
    if (full_speed)
      chk("frame_cycles", done_at, 18);
    for (int i = 0; i < N; i++)
      if (pk[i] > 0) pk[i]--;
    frame_req = req_at_done;
    if (req_at_done) bump_ovr();
    col_ready = 1'b0;
    step();
    frame_req = 1'b0;
    chk("done_one_cycle", 32'(frame_done), 0);
    chk("idle_after_done", 32'(frame_busy), 0);
    chk("valid_idle", 32'(col_valid), 0);
    chk("overrun", 32'(overrun_cnt), exp_ovr);
    step();
    chk("still_idle", 32'(frame_busy), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    frame_req = 1'b0;
    col_ready = 1'b0;
    values_in = '0;
    for (int i = 0; i < N; i++) pk[i] = 0;

    for (int i = 0; i < 4; i++) begin
      frame_req = ~frame_req;
      step();
    end
    frame_req = 1'b0;
    chk("rst_valid", 32'(col_valid), 0);
    chk("rst_busy", 32'(frame_busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_idx", 32'(col_index), 0);
    chk("rst_bar", 32'(col_bar), 0);
    chk("rst_ovr", 32'(overrun_cnt), 0);
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_busy", 32'(frame_busy), 0);
    chk("post_rst_valid", 32'(col_valid), 0);

    for (int i = 0; i < N; i++)
      values_in[i*VW +: VW] = VW'(i);
    run_frame(1'b0, 0, 1'b0, 1'b1);

    for (int f = 0; f < 3; f++) begin
      rand_values(f == 0 ? 12 : 300);
      run_frame(1'b1, 0, 1'b0, 1'b0);
    end

    rand_values(10);
    run_frame(1'b1, 3, 1'b0, 1'b0);
    chk("overrun_three", 32'(overrun_cnt), 3);
    rand_values(10);
    run_frame(1'b0, 0, 1'b1, 1'b1);

    rand_values(10);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    col_ready = 1'b1;
    step();
    for (int i = 0; i < 20 && col_index != 4'd7; i++)
      step();
    col_ready = 1'b0;
    chk("mid_idx7", 32'(col_index), 7);
    chk("mid_bar7", 32'(col_bar), ref_bar(ref_lvl(val_of(7))));
    frame_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      bump_ovr();
    end
    frame_req = 1'b0;
    chk("overrun_sat", 32'(overrun_cnt), 255);
    chk("stall_idx", 32'(col_index), 7);
    chk("stall_valid", 32'(col_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(col_valid), 0);
    chk("async_busy", 32'(frame_busy), 0);
    chk("async_ovr", 32'(overrun_cnt), 0);
    exp_ovr = 0;
    for (int i = 0; i < N; i++) pk[i] = 0;
    step();
    chk("abort_no_done", 32'(frame_done), 0);
    step();
    reset_n = 1'b1;
    step();
    chk("abort_no_done2", 32'(frame_done), 0);
    rand_values(12);
    run_frame(1'b1, 0, 1'b0, 1'b0);

`ifdef PEAK_HOLD_EN
    values_in = '0;
    values_in[VW-1:0] = VW'(6);
    run_frame(1'b0, 0, 1'b0, 1'b1);
    values_in[VW-1:0] = VW'(2);
    run_frame(1'b1, 0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
